// File: rtl/pipeline_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_if
//   Bundles the request and control signals between the pipeline sequencing
//   controller and the core's stage datapaths.
//
//   master : the sequencing controller. It receives the hazard, branch,
//            exception and halt requests, and drives the buffer enables,
//            flushes, valid bits, state flag and performance counters.
//   slave  : the core side. It raises the requests and consumes the controls.
//
//   Parameters
//     STAGES : number of pipeline stages (index 0 = fetch)
//     CNT_W  : performance counter width
// ----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
    parameter int STAGES = 5,
    parameter int CNT_W  = 32
) ();
    // Requests from the core
    logic              fetch_valid;
    logic              stall_req;
    logic              mispredict;
    logic              exc_req;
    logic              halt_retire;
    logic              halt_req;
    logic              resume;

    // Controls and status back to the core
    logic              pc_write;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] flush;
    logic [STAGES-1:0] stage_valid;
    logic              halted;
    logic [CNT_W-1:0]  cycles;
    logic [CNT_W-1:0]  retired;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        input  fetch_valid, stall_req, mispredict, exc_req,
        input  halt_retire, halt_req, resume,
        output pc_write, stage_en, flush, stage_valid, halted,
        output cycles, retired, stall_cycles, flush_count
    );

    modport slave (
        output fetch_valid, stall_req, mispredict, exc_req,
        output halt_retire, halt_req, resume,
        input  pc_write, stage_en, flush, stage_valid, halted,
        input  cycles, retired, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
//   Sequencing controller for a pipelined core with any number of stages.
//   Tracks one valid bit per stage and, every cycle, decides which inter-stage
//   buffers capture, which load a bubble, and whether the PC advances.
//   A RUN / DRAIN / HALTED state machine lets the core drain and stop either
//   on an external request or when a halt instruction retires.
//   Four saturating performance counters are maintained.
//
//   Ports
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : pipeline_ctrl_if.master
//            in : fetch_valid, stall_req, mispredict, exc_req,
//                 halt_retire, halt_req, resume
//            out: pc_write, stage_en, flush (combinational, same cycle)
//                 stage_valid, halted, cycles, retired, stall_cycles,
//                 flush_count (registered)
//
//   Request priority within one cycle: exc_req > mispredict > stall_req.
//   In HALTED every request except resume is ignored and all valids hold.
// ----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int STAGES    = 5,
    parameter int CNT_W     = 32,
    parameter int HAZ_STAGE = 1,
    parameter int BR_STAGE  = 2,
    parameter int EXC_STAGE = 1
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.master bus
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // Mask with bits 0..top set (top < 0 gives an empty mask).
    function automatic logic [STAGES-1:0] low_mask(input int top);
        logic [STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (i <= top) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // Saturating increment: sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        logic [CNT_W-1:0] r;
        if (en && !(&v)) begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Stages squashed by an exception: the excepting instruction and every
    // younger one, including the one about to enter EXC_STAGE+1.
    localparam logic [STAGES-1:0] EXC_KILL  = low_mask(EXC_STAGE + 1);
    // Stages squashed by a mispredict: everything younger than the branch;
    // the branch itself moves on to BR_STAGE+1.
    localparam logic [STAGES-1:0] BR_KILL   = low_mask(BR_STAGE);
    // Stages frozen by a load-use stall.
    localparam logic [STAGES-1:0] HAZ_HOLD  = low_mask(HAZ_STAGE);
    // The buffer just below the stalled stage receives the bubble.
    localparam logic [STAGES-1:0] HAZ_BUB   = low_mask(HAZ_STAGE + 1) & ~low_mask(HAZ_STAGE);
    localparam logic [STAGES-1:0] FETCH_BIT = low_mask(0);

    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic              halted_r;
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] valid_nx_s;
    logic [STAGES-1:0] shift_s;
    logic [STAGES-1:0] kill_s;
    logic [STAGES-1:0] hold_s;
    logic [STAGES-1:0] flush_s;
    logic [STAGES-1:0] stage_en_s;
    logic              pc_write_s;
    logic              exc_hon_s;
    logic              mis_hon_s;
    logic              stall_hon_s;
    logic              not_halted_s;
    logic [CNT_W-1:0]  cycles_r;
    logic [CNT_W-1:0]  retired_r;
    logic [CNT_W-1:0]  stall_cycles_r;
    logic [CNT_W-1:0]  flush_count_r;

    assign not_halted_s = (state_r != ST_HALTED);

    // Valid-bit advance, kill/hold masks, PC enable and honoured requests.
    always_comb begin
        kill_s      = '0;
        hold_s      = '0;
        exc_hon_s   = 1'b0;
        mis_hon_s   = 1'b0;
        stall_hon_s = 1'b0;
        pc_write_s  = 1'b0;
        shift_s     = {valid_r[STAGES-2:0], 1'b0};
        valid_nx_s  = valid_r;
        if (state_r == ST_HALTED) begin
            valid_nx_s = valid_r;
        end else begin
            // In RUN fetch feeds stage 0; in DRAIN stage 0 is forced empty,
            // which counts as a bubble load.
            if (state_r == ST_RUN) begin
                shift_s[0] = bus.fetch_valid;
            end else begin
                kill_s = FETCH_BIT;
            end

            if (bus.exc_req) begin
                exc_hon_s = 1'b1;
                kill_s    = kill_s | EXC_KILL;
            end else if (bus.mispredict) begin
                mis_hon_s = 1'b1;
                kill_s    = kill_s | BR_KILL;
            end else if (bus.stall_req) begin
                stall_hon_s = 1'b1;
                hold_s      = HAZ_HOLD;
                kill_s      = kill_s | HAZ_BUB;
            end else begin
                stall_hon_s = 1'b0;
            end

            valid_nx_s = (valid_r & hold_s) | (shift_s & ~hold_s & ~kill_s);

            if (state_r == ST_RUN) begin
                pc_write_s = !bus.stall_req || bus.exc_req || bus.mispredict;
            end else begin
                pc_write_s = bus.exc_req || bus.mispredict;
            end
        end
    end

    // Buffer controls: held stages do not capture; a held stage never also
    // reports a flush (matters for stage 0 while draining under a stall).
    always_comb begin
        flush_s    = kill_s & ~hold_s;
        stage_en_s = '0;
        if (state_r == ST_HALTED) begin
            stage_en_s = '0;
        end else begin
            stage_en_s = ~hold_s;
        end
    end

    // RUN / DRAIN / HALTED next state; a retiring halt wins over halt_req.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (valid_r[STAGES-1] && bus.halt_retire) begin
                    state_nx_s = ST_HALTED;
                end else if (bus.halt_req) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (valid_r[STAGES-1] && bus.halt_retire) begin
                    state_nx_s = ST_HALTED;
                end else if (valid_r == '0) begin
                    state_nx_s = ST_HALTED;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                if (bus.resume) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_HALTED;
                end
            end
            default: begin
                state_nx_s = ST_RUN;
            end
        endcase
    end

    // State, valid bits and halted flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
            valid_r  <= '0;
        end else begin
            state_r  <= state_nx_s;
            halted_r <= (state_nx_s == ST_HALTED);
            valid_r  <= valid_nx_s;
        end
    end

    // Performance counters; the retiring halt is counted on the entry edge
    // because the increment looks at the pre-edge state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_r       <= '0;
            retired_r      <= '0;
            stall_cycles_r <= '0;
            flush_count_r  <= '0;
        end else begin
            cycles_r       <= sat_inc(cycles_r, not_halted_s);
            retired_r      <= sat_inc(retired_r, valid_r[STAGES-1] && not_halted_s);
            stall_cycles_r <= sat_inc(stall_cycles_r, stall_hon_s);
            flush_count_r  <= sat_inc(flush_count_r, exc_hon_s || mis_hon_s);
        end
    end

    assign bus.pc_write     = pc_write_s;
    assign bus.stage_en     = stage_en_s;
    assign bus.flush        = flush_s;
    assign bus.stage_valid  = valid_r;
    assign bus.halted       = halted_r;
    assign bus.cycles       = cycles_r;
    assign bus.retired      = retired_r;
    assign bus.stall_cycles = stall_cycles_r;
    assign bus.flush_count  = flush_count_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Self-checking bench for pipeline_ctrl (STAGES=5, HAZ=1, BR=2, EXC=1).
//   A second instance with CNT_W=4 shares the same stimulus to exercise
//   counter saturation. A rule-level reference model predicts every output.
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;
    localparam int S   = 5;
    localparam int HAZ = 1;
    localparam int BR  = 2;
    localparam int EXC = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.STAGES(S), .CNT_W(32)) bus ();
    pipeline_ctrl_if #(.STAGES(S), .CNT_W(4))  sbus ();

    pipeline_ctrl #(.STAGES(S), .CNT_W(32), .HAZ_STAGE(HAZ), .BR_STAGE(BR), .EXC_STAGE(EXC))
        dut (.clk(clk), .rst(rst), .bus(bus));
    pipeline_ctrl #(.STAGES(S), .CNT_W(4), .HAZ_STAGE(HAZ), .BR_STAGE(BR), .EXC_STAGE(EXC))
        dut_sat (.clk(clk), .rst(rst), .bus(sbus));

    assign sbus.fetch_valid = bus.fetch_valid;
    assign sbus.stall_req   = bus.stall_req;
    assign sbus.mispredict  = bus.mispredict;
    assign sbus.exc_req     = bus.exc_req;
    assign sbus.halt_retire = bus.halt_retire;
    assign sbus.halt_req    = bus.halt_req;
    assign sbus.resume      = bus.resume;

    // ---------------- reference model ----------------
    typedef enum int {M_RUN, M_DRAIN, M_HALTED} mstate_t;
    mstate_t   m_state, n_state;
    bit [S-1:0] m_v, n_v, e_en, e_fl;
    bit         e_pc, n_hs, n_hf;
    longint     m_cyc, m_ret, m_stall, m_fl;

    int passed = 0;
    int total  = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic longint satv(longint x, int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    task automatic model_reset();
        m_state = M_RUN; m_v = '0;
        m_cyc = 0; m_ret = 0; m_stall = 0; m_fl = 0;
    endtask

    // Apply the sequencing rules to the current model state and inputs.
    task automatic model_eval(input bit fv, st, mi, ex, hr, hq, rs);
        int kill_to, hold_to;
        kill_to = -1; hold_to = -1;
        e_en = '1; e_fl = '0; e_pc = 1'b0; n_v = m_v; n_state = m_state;
        n_hs = 1'b0; n_hf = 1'b0;
        if (m_state == M_HALTED) begin
            e_en = '0;
            n_state = rs ? M_RUN : M_HALTED;
        end else begin
            if (ex)      begin kill_to = EXC + 1; n_hf = 1'b1; end
            else if (mi) begin kill_to = BR;      n_hf = 1'b1; end
            else if (st) begin hold_to = HAZ;     n_hs = 1'b1; end
            for (int i = S - 1; i >= 0; i--) begin
                if (i <= hold_to) begin
                    n_v[i] = m_v[i]; e_en[i] = 1'b0;
                end else if (i <= kill_to || (n_hs && i == hold_to + 1)) begin
                    n_v[i] = 1'b0; e_fl[i] = 1'b1;
                end else if (i == 0) begin
                    if (m_state == M_RUN) n_v[0] = fv;
                    else begin n_v[0] = 1'b0; e_fl[0] = 1'b1; end
                end else begin
                    n_v[i] = m_v[i-1];
                end
            end
            e_pc = (m_state == M_RUN) ? (!st || ex || mi) : (ex || mi);
            if (m_v[S-1] && hr)                 n_state = M_HALTED;
            else if (m_state == M_RUN && hq)    n_state = M_DRAIN;
            else if (m_state == M_DRAIN && m_v == '0) n_state = M_HALTED;
        end
    endtask

    task automatic model_commit();
        if (m_state != M_HALTED) begin
            m_cyc++;
            if (m_v[S-1]) m_ret++;
        end
        if (n_hs) m_stall++;
        if (n_hf) m_fl++;
        m_v = n_v; m_state = n_state;
    endtask

    task automatic check_regs();
        chk("stage_valid", bus.stage_valid, m_v);
        chk("halted", bus.halted, (m_state == M_HALTED));
        chk("cycles", bus.cycles, m_cyc);
        chk("retired", bus.retired, m_ret);
        chk("stall_cycles", bus.stall_cycles, m_stall);
        chk("flush_count", bus.flush_count, m_fl);
        chk("sat_cycles", sbus.cycles, satv(m_cyc, 4));
        chk("sat_retired", sbus.retired, satv(m_ret, 4));
        chk("sat_stall", sbus.stall_cycles, satv(m_stall, 4));
        chk("sat_flush", sbus.flush_count, satv(m_fl, 4));
    endtask

    // One clock: drive at negedge, check combinational outputs, then the edge.
    task automatic step(input bit fv, st, mi, ex, hr, hq, rs,
                        output logic pc_o, output logic [S-1:0] en_o, fl_o);
        bus.fetch_valid = fv; bus.stall_req = st; bus.mispredict = mi;
        bus.exc_req = ex; bus.halt_retire = hr; bus.halt_req = hq; bus.resume = rs;
        #2;
        model_eval(fv, st, mi, ex, hr, hq, rs);
        pc_o = bus.pc_write; en_o = bus.stage_en; fl_o = bus.flush;
        chk("pc_write", bus.pc_write, e_pc);
        chk("stage_en", bus.stage_en, e_en);
        chk("flush", bus.flush, e_fl);
        @(posedge clk); #1;
        model_commit();
        check_regs();
        @(negedge clk);
    endtask

    typedef struct {
        bit fv, st, mi, ex;
        bit pc;
        bit [S-1:0] en, fl, nv;
    } vec_t;
    vec_t tbl[16];

    initial begin
        logic pc_o;
        logic [S-1:0] en_o, fl_o;
        int edges;
        longint frozen;

        tbl[0]  = '{1,0,0,0, 1, 5'b11111, 5'b00000, 5'b00001};
        tbl[1]  = '{1,0,0,0, 1, 5'b11111, 5'b00000, 5'b00011};
        tbl[2]  = '{1,0,0,0, 1, 5'b11111, 5'b00000, 5'b00111};
        tbl[3]  = '{1,0,0,0, 1, 5'b11111, 5'b00000, 5'b01111};
        tbl[4]  = '{1,0,0,0, 1, 5'b11111, 5'b00000, 5'b11111};
        tbl[5]  = '{1,1,0,0, 0, 5'b11100, 5'b00100, 5'b11011};
        tbl[6]  = '{1,0,0,0, 1, 5'b11111, 5'b00000, 5'b10111};
        tbl[7]  = '{1,0,0,0, 1, 5'b11111, 5'b00000, 5'b01111};
        tbl[8]  = '{1,0,0,0, 1, 5'b11111, 5'b00000, 5'b11111};
        tbl[9]  = '{1,1,1,0, 1, 5'b11111, 5'b00111, 5'b11000};
        tbl[10] = '{1,0,0,0, 1, 5'b11111, 5'b00000, 5'b10001};
        tbl[11] = '{1,0,0,0, 1, 5'b11111, 5'b00000, 5'b00011};
        tbl[12] = '{1,0,0,0, 1, 5'b11111, 5'b00000, 5'b00111};
        tbl[13] = '{1,0,0,0, 1, 5'b11111, 5'b00000, 5'b01111};
        tbl[14] = '{1,0,0,0, 1, 5'b11111, 5'b00000, 5'b11111};
        tbl[15] = '{1,0,1,1, 1, 5'b11111, 5'b00111, 5'b11000};

        rst = 1'b1;
        bus.fetch_valid = 1'b0; bus.stall_req = 1'b0; bus.mispredict = 1'b0;
        bus.exc_req = 1'b0; bus.halt_retire = 1'b0; bus.halt_req = 1'b0; bus.resume = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_stage_valid", bus.stage_valid, 5'b00000);
        chk("rst_halted", bus.halted, 1'b0);
        chk("rst_cycles", bus.cycles, 32'd0);
        chk("rst_retired", bus.retired, 32'd0);
        chk("rst_counters", {bus.stall_cycles, bus.flush_count}, 64'd0);
        chk("rst_pc_write", bus.pc_write, 1'b1);
        chk("rst_stage_en", bus.stage_en, 5'b11111);
        chk("rst_flush", bus.flush, 5'b00000);
        rst = 1'b0;

        // Fill, stall, mispredict+stall, exception+mispredict
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].fv, tbl[i].st, tbl[i].mi, tbl[i].ex, 1'b0, 1'b0, 1'b0, pc_o, en_o, fl_o);
            chk($sformatf("row%0d_pc", i), pc_o, tbl[i].pc);
            chk($sformatf("row%0d_en", i), en_o, tbl[i].en);
            chk($sformatf("row%0d_flush", i), fl_o, tbl[i].fl);
            chk($sformatf("row%0d_valid", i), bus.stage_valid, tbl[i].nv);
        end
        chk("tbl_stall_cycles", bus.stall_cycles, 32'd1);
        chk("tbl_flush_count", bus.flush_count, 32'd2);

        // Refill, then drain on halt_req
        repeat (5) step(1, 0, 0, 0, 0, 0, 0, pc_o, en_o, fl_o);
        chk("refill_valid", bus.stage_valid, 5'b11111);
        step(0, 0, 0, 0, 0, 1, 0, pc_o, en_o, fl_o);
        chk("drain_entry_halted", bus.halted, 1'b0);
        edges = 0;
        while (!bus.halted && edges < 10) begin
            step(1, 0, 0, 0, 0, 0, 0, pc_o, en_o, fl_o);
            chk("drain_pc_write", pc_o, 1'b0);
            edges++;
        end
        chk("drain_edges", edges, 5);
        chk("drain_halted", bus.halted, 1'b1);

        // Frozen while halted; requests ignored
        frozen = m_cyc;
        repeat (3) step(1, 1, 1, 0, 0, 1, 0, pc_o, en_o, fl_o);
        chk("halted_cycles_frozen", bus.cycles, frozen);
        chk("halted_stage_en", en_o, 5'b00000);
        step(0, 0, 0, 0, 0, 0, 1, pc_o, en_o, fl_o);
        chk("resume_halted", bus.halted, 1'b0);
        step(1, 0, 0, 0, 0, 0, 0, pc_o, en_o, fl_o);
        chk("resume_pc_write", pc_o, 1'b1);

        // Halt instruction retiring from the last stage
        repeat (4) step(1, 0, 0, 0, 0, 0, 0, pc_o, en_o, fl_o);
        chk("pre_halt_valid", bus.stage_valid, 5'b11111);
        step(1, 0, 0, 0, 1, 0, 0, pc_o, en_o, fl_o);
        chk("halt_retire_halted", bus.halted, 1'b1);
        step(1, 0, 0, 0, 0, 0, 0, pc_o, en_o, fl_o);
        chk("halt_retire_en", en_o, 5'b00000);
        chk("halt_retire_pc", pc_o, 1'b0);
        chk("sat_cycles_stuck", sbus.cycles, 4'hF);

        // Reset while halted
        rst = 1'b1; #2;
        model_reset();
        chk("rst_halted_valid", bus.stage_valid, 5'b00000);
        chk("rst_halted_flag", bus.halted, 1'b0);
        @(negedge clk); rst = 1'b0;

        // Reset in the middle of a drain
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, pc_o, en_o, fl_o);
        step(1, 0, 0, 0, 0, 1, 0, pc_o, en_o, fl_o);
        step(0, 0, 0, 0, 0, 0, 0, pc_o, en_o, fl_o);
        chk("mid_drain_pc", pc_o, 1'b0);
        rst = 1'b1; #2;
        model_reset();
        chk("rst_drain_valid", bus.stage_valid, 5'b00000);
        chk("rst_drain_pc", bus.pc_write, 1'b1);
        @(negedge clk); rst = 1'b0;

        // Randomised traffic against the model
        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 9) < 3, pc_o, en_o, fl_o);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
